// File: rtl/lbp_hdc_encoder.sv
// LBP hyperdimensional encoder: window samples -> LBP codes -> channel-bound, spatially and temporally bundled window HV.
// Latency 1 cycle (registered window_hv); free-running, no handshake or backpressure.
module lbp_hdc_encoder #(
  parameter int                    DIMENSIONS  = 10000,
  parameter int                    WINDOW_SIZE = 2,
  parameter int                    LBP_SIZE    = 6,
  parameter int                    NUM_LBP     = 64,
  parameter int                    NUM_CHS     = 2,
  parameter int                    NUM_REGS    = 16,
  parameter logic [NUM_REGS-1:0]   SEED        = 16'h94B5,
  parameter int                    NUM_VALS    = 10000,
  parameter logic [DIMENSIONS-1:0] START_VAL   = {(DIMENSIONS+15)/16{16'hC3A5}}
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  real                   sample_array [NUM_CHS][WINDOW_SIZE+LBP_SIZE],
  input  logic [1:0]            feature_set,
  output logic [DIMENSIONS-1:0] window_hv
);

  function automatic logic [DIMENSIONS-1:0] rotl(input logic [DIMENSIONS-1:0] x, input int sh);
    logic [2*DIMENSIONS-1:0] t;
    t = {x, x} << sh;
    return t[2*DIMENSIONS-1:DIMENSIONS];
  endfunction

  // Channel HVs are consecutive NUM_VALS-bit slices of one LFSR stream; loops are
  // blocked in 64s so elaboration-time evaluation stays within loop limits.
  function automatic logic [NUM_CHS-1:0][DIMENSIONS-1:0] gen_ch();
    logic [NUM_CHS-1:0][DIMENSIONS-1:0] ch;
    logic [NUM_REGS-1:0]                r;
    int                                 n;
    ch = '0;
    r  = SEED;
    for (int c = 0; c < NUM_CHS; c++) begin
      for (int blk = 0; blk < (NUM_VALS + 63) / 64; blk++) begin
        for (int b = 0; b < 64; b++) begin
          n = blk * 64 + b;
          if (n < NUM_VALS) begin
            ch[c][n] = r[NUM_REGS-1];
            r = {r[NUM_REGS-2:0],
                 r[NUM_REGS-1] ^ r[NUM_REGS-3] ^ r[NUM_REGS-4] ^ r[NUM_REGS-6]};
          end
        end
      end
    end
    return ch;
  endfunction

  localparam logic [NUM_CHS-1:0][DIMENSIONS-1:0] CH_HV = gen_ch();
  localparam logic [DIMENSIONS-1:0]              TB_HV = rotl(START_VAL, DIMENSIONS - 1);

  function automatic logic [DIMENSIONS-1:0] bundle_ch(input logic [NUM_CHS-1:0][DIMENSIONS-1:0] hv);
    logic [DIMENSIONS-1:0] r;
    int                    cnt;
    r = '0;
    for (int d = 0; d < DIMENSIONS; d++) begin
      cnt = 0;
      for (int c = 0; c < NUM_CHS; c++) cnt += int'(hv[c][d]);
      if (2 * cnt > NUM_CHS)       r[d] = 1'b1;
      else if (2 * cnt == NUM_CHS) r[d] = TB_HV[d];
    end
    return r;
  endfunction

  function automatic logic [DIMENSIONS-1:0] bundle_win(input logic [WINDOW_SIZE-1:0][DIMENSIONS-1:0] hv);
    logic [DIMENSIONS-1:0] r;
    int                    cnt;
    r = '0;
    for (int d = 0; d < DIMENSIONS; d++) begin
      cnt = 0;
      for (int w = 0; w < WINDOW_SIZE; w++) cnt += int'(hv[w][d]);
      if (2 * cnt > WINDOW_SIZE)       r[d] = 1'b1;
      else if (2 * cnt == WINDOW_SIZE) r[d] = TB_HV[d];
    end
    return r;
  endfunction

  logic [LBP_SIZE-1:0]                    lbp;
  logic [NUM_CHS-1:0][DIMENSIONS-1:0]     bound;
  logic [WINDOW_SIZE-1:0][DIMENSIONS-1:0] spatial;
  logic [DIMENSIONS-1:0]                  window_lbp;
  logic [DIMENSIONS-1:0]                  window_hv_d;
  logic [DIMENSIONS-1:0]                  window_hv_q;

  // Item-memory lookup is a rotation of a constant, so it folds to a fixed mux.
  always_comb begin
    lbp     = '0;
    bound   = '0;
    spatial = '0;
    for (int w = 0; w < WINDOW_SIZE; w++) begin
      for (int c = 0; c < NUM_CHS; c++) begin
        for (int k = 0; k < LBP_SIZE; k++) begin
          lbp[k] = sample_array[c][w+k+1] > sample_array[c][w+k];
        end
        bound[c] = rotl(START_VAL, int'(lbp) % NUM_LBP) ^ CH_HV[c];
      end
      spatial[w] = bundle_ch(bound);
    end
    window_lbp  = bundle_win(spatial);
    window_hv_d = (feature_set == 2'd0) ? window_lbp : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) window_hv_q <= '0;
    else       window_hv_q <= window_hv_d;
  end

  assign window_hv = window_hv_q;

endmodule

// File: tb/tb_lbp_hdc_encoder.sv
// Scoreboard bench for lbp_hdc_encoder: directed sample windows with hand-derived LBP codes.
module tb_lbp_hdc_encoder;
  localparam int D  = 10000;
  localparam int NS = 8;

  logic          clk;
  logic          nrst;
  logic [1:0]    fs;
  logic [D-1:0]  window_hv;
  real           smp [2][NS];

  logic [5:0]    codes [2][2];
  logic [D-1:0]  sv;
  logic [D-1:0]  tbv;
  logic [D-1:0]  chv [2];

  logic [D-1:0]  exp_q [$];
  int            due_q [$];
  string         name_q [$];
  logic [D-1:0]  mon_exp;
  string         mon_name;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  lbp_hdc_encoder dut (
    .clk          (clk),
    .nrst         (nrst),
    .sample_array (smp),
    .feature_set  (fs),
    .window_hv    (window_hv)
  );

  initial begin
    clk = 1'b0;
    #5;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic init_model();
    logic [15:0] pat;
    logic [15:0] lfsr;
    logic        fb;
    pat = 16'hC3A5;
    for (int d = 0; d < D; d++) sv[d] = pat[d % 16];
    for (int d = 0; d < D; d++) tbv[d] = sv[(d + 1) % D];
    lfsr = 16'h94B5;
    for (int n = 0; n < 2 * D; n++) begin
      chv[n / D][n % D] = lfsr[15];
      fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
      lfsr = {lfsr[14:0], fb};
    end
  endtask

  // Bitwise model: item HV bit d of code i is START_VAL[d-i mod D].
  function automatic logic [D-1:0] model();
    logic [D-1:0] r;
    int           nc;
    int           nw;
    logic         b;
    r = '0;
    for (int d = 0; d < D; d++) begin
      nw = 0;
      for (int w = 0; w < 2; w++) begin
        nc = 0;
        for (int c = 0; c < 2; c++) begin
          b = sv[(d - int'(codes[c][w]) + D) % D] ^ chv[c][d];
          if (b) nc++;
        end
        if (nc == 2 || (nc == 1 && tbv[d])) nw++;
      end
      r[d] = (nw == 2) || (nw == 1 && tbv[d]);
    end
    return r;
  endfunction

  task automatic push(input string nm, input int due, input logic zero);
    logic [D-1:0] e;
    if (zero) e = '0;
    else      e = model();
    exp_q.push_back(e);
    due_q.push_back(due);
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm);
    push(nm, cyc + 1, fs != 2'd0);
    @(negedge clk);
  endtask

  task automatic ramp(input int c, input real base, input real st);
    for (int i = 0; i < NS; i++) smp[c][i] = base + st * real'(i);
  endtask

  task automatic ch0_vector();
    smp[0][0] =  4.884e-6; smp[0][1] =  1.368e-6; smp[0][2] = -6.447e-6; smp[0][3] = -1.661e-5;
    smp[0][4] = -2.598e-5; smp[0][5] = -4.239e-5; smp[0][6] = -5.138e-5; smp[0][7] =  4.884e-6;
  endtask

  task automatic set_codes(input logic [5:0] c0w0, input logic [5:0] c0w1,
                           input logic [5:0] c1w0, input logic [5:0] c1w1);
    codes[0][0] = c0w0; codes[0][1] = c0w1;
    codes[1][0] = c1w0; codes[1][1] = c1w1;
  endtask

  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      void'(due_q.pop_front());
      checks++;
      if (window_hv !== mon_exp) begin
        failures++;
        $display("FAIL %s: got[31:0]=%h want[31:0]=%h differing_bits=%0d",
                 mon_name, window_hv[31:0], mon_exp[31:0], $countones(window_hv ^ mon_exp));
      end
    end
  end

  initial begin
    nrst = 1'b0;
    fs   = 2'd0;
    ramp(0, 1e-6, 1e-6);
    ramp(1, 1e-6, 1e-6);
    set_codes(6'd63, 6'd63, 6'd63, 6'd63);
    init_model();

    @(negedge clk);
    push("reset_hold", cyc + 1, 1'b1);
    @(negedge clk);
    nrst = 1'b1;
    step("inc_after_reset");

    ramp(0, 8e-6, -1e-6); ramp(1, 8e-6, -1e-6);
    set_codes(6'd0, 6'd0, 6'd0, 6'd0);
    step("dec_ramp");

    ramp(0, 3e-6, 0.0); ramp(1, 3e-6, 0.0);
    step("flat");

    ch0_vector(); ramp(1, 8e-6, -1e-6);
    set_codes(6'd0, 6'd32, 6'd0, 6'd0);
    step("ch0_vector");

    ramp(0, 8e-6, -1e-6); ramp(1, -4e-6, 1e-6);
    set_codes(6'd0, 6'd0, 6'd63, 6'd63);
    step("tie_0_63");

    ch0_vector(); ramp(1, -4e-6, 1e-6);
    set_codes(6'd0, 6'd32, 6'd63, 6'd63);
    step("mixed");

    fs = 2'd1; step("fs1");
    fs = 2'd2; step("fs2");
    fs = 2'd3; step("fs3");
    fs = 2'd0; step("fs_back");
    step("hold");

    @(posedge clk);
    #2;
    nrst = 1'b0;
    push("mid_reset", cyc, 1'b1);
    @(negedge clk);
    nrst = 1'b1;
    step("after_mid_reset");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
